ifetch_queue: RTL and testbench

Instruction-fetch stage sitting directly upstream of the decode/register-file stage. It owns the program counter, drives `imem` with word addresses, and captures returned instructions into a 2-entry FIFO tagged with their PC. The FIFO head is presented to decode through a valid/ready handshake, with rs1/rs2/rd pre-extracted for `regfile`. Branch/jump redirects flush the queue and reload the PC.

---
 rtl/ifetch_queue.sv | 133 +++++++++++++
 tb/tb_ifetch_queue.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// Instruction-fetch stage: owns the PC, fetches from imem and buffers {pc, instr} in a 2-entry FIFO for decode.
// Optional misaligned-redirect trap is enabled by defining IFETCH_ALIGN_CHECK_EN.
`ifndef REG_SIZE
`define REG_SIZE 32
`endif
`ifndef REG_ADDR_SIZE
`define REG_ADDR_SIZE 5
`endif

module ifetch_queue #(
  parameter logic [`REG_SIZE-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic [`REG_SIZE-1:0]      iaddr,
  input  logic [`REG_SIZE-1:0]      idata,
  input  logic                      redir_valid,
  input  logic [`REG_SIZE-1:0]      redir_pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [`REG_SIZE-1:0]      out_pc,
  output logic [`REG_SIZE-1:0]      out_instr,
  output logic [`REG_ADDR_SIZE-1:0] rs1,
  output logic [`REG_ADDR_SIZE-1:0] rs2,
  output logic [`REG_ADDR_SIZE-1:0] rd,
  output logic                      misalign
);

  localparam int W = `REG_SIZE;

  logic [W-1:0] pc;
  logic [W-1:0] q_pc    [2];
  logic [W-1:0] q_instr [2];
  logic         head;
  logic         tail;
  logic [1:0]   count;
  logic [W-1:0] head_pc,   head_pc_n;
  logic [W-1:0] head_instr, head_instr_n;

  logic         halted;
  logic         redir_take;
  logic [W-1:0] redir_target;
  logic         pop;
  logic         push;
  logic         keeps_entry;

`ifdef IFETCH_ALIGN_CHECK_EN
  logic misalign_q;

  // Once trapped, redirects are ignored until reset.
  assign halted       = misalign_q;
  assign redir_take   = redir_valid && !misalign_q;
  assign redir_target = redir_pc;
  assign misalign     = misalign_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      misalign_q <= 1'b0;
    else if (redir_take && (redir_pc[1:0] != 2'b00))
      misalign_q <= 1'b1;
  end
`else
  assign halted       = 1'b0;
  assign redir_take   = redir_valid;
  assign redir_target = {redir_pc[W-1:2], 2'b00};
  assign misalign     = 1'b0;
`endif

  assign iaddr     = pc;
  assign out_valid = (count != 2'd0);
  assign out_pc    = head_pc;
  assign out_instr = head_instr;
  assign rs1       = head_instr[19:15];
  assign rs2       = head_instr[24:20];
  assign rd        = head_instr[11:7];

  assign pop         = out_valid && out_ready;
  assign push        = !redir_take && !halted && ((count != 2'd2) || pop);
  assign keeps_entry = (count == 2'd2) || ((count == 2'd1) && !pop);

  // The head is held in registers so an emptied queue keeps presenting its last entry.
  always_comb begin
    // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
    head_pc_n    = head_pc;
    head_instr_n = head_instr;
    if (!redir_take) begin
      if (keeps_entry) begin
        head_pc_n    = q_pc[head ^ pop];
        head_instr_n = q_instr[head ^ pop];
      end else if (push) begin
        head_pc_n    = pc;
        head_instr_n = idata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc         <= RESET_PC;
      head       <= 1'b0;
      tail       <= 1'b0;
      count      <= 2'd0;
      head_pc    <= '0;
      head_instr <= '0;
      // NOTE: the two storage entries are cleared on reset; the head must read as zero afterwards.
      for (int i = 0; i < 2; i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
      end
    end else begin
      // NOTE: all state uses non-blocking assignments so every read sees pre-edge values.
      head_pc    <= head_pc_n;
      head_instr <= head_instr_n;
      if (redir_take) begin
        count <= 2'd0;
        head  <= 1'b0;
        tail  <= 1'b0;
        pc    <= redir_target;
      end else begin
        if (push) begin
          q_pc[tail]    <= pc;
          q_instr[tail] <= idata;
          tail          <= ~tail;
          pc            <= pc + 32'd4;
        end
        if (pop)
          head <= ~head;
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: a queue of expected {pc, instr} entries is filled as fetches occur
// and drained as decode accepts heads; outputs are compared away from the rising edge.
module tb_ifetch_queue;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic        clk;
  logic        reset;
  logic [31:0] iaddr;
  logic [31:0] idata;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        misalign;

  int          checks = 0;
  int          errors = 0;
  entry_t      sb[$];
  logic [31:0] model_pc;

  ifetch_queue #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .iaddr       (iaddr),
    .idata       (idata),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .misalign    (misalign)
  );

  // Combinational instruction memory: a fixed decode-test word at 0x100, a hash of the word index elsewhere.
  function automatic logic [31:0] imem(input logic [31:0] addr);
    if (addr == 32'h0000_0100) return 32'h00B5_0533;
    return ((addr >> 2) * 32'h9E37_79B9) ^ 32'h1357_0000;
  endfunction

  assign idata = imem(iaddr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs at the falling edge, compare against the scoreboard, update it, cross the rising edge.
  task automatic step(input logic rv, input logic [31:0] rp, input logic rdy);
    logic   pop;
    entry_t e;
    redir_valid = rv;
    redir_pc    = rp;
    out_ready   = rdy;
    #1;
    check("out_valid", {31'b0, out_valid}, {31'b0, sb.size() != 0});
    check("iaddr", iaddr, model_pc);
    check("misalign", {31'b0, misalign}, 32'd0);
    if (sb.size() != 0) begin
      e = sb[0];
      check("out_pc", out_pc, e.pc);
      check("out_instr", out_instr, e.instr);
      check("rs1", {27'b0, rs1}, {27'b0, e.instr[19:15]});
      check("rs2", {27'b0, rs2}, {27'b0, e.instr[24:20]});
      check("rd", {27'b0, rd}, {27'b0, e.instr[11:7]});
    end
    pop = (sb.size() != 0) && rdy;
    if (rv) begin
      sb.delete();
      model_pc = {rp[31:2], 2'b00};
    end else begin
      if (pop) void'(sb.pop_front());
      if (sb.size() < 2) begin
        sb.push_back('{pc: model_pc, instr: imem(model_pc)});
        model_pc = model_pc + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset       = 1'b1;
    redir_valid = 1'b0;
    redir_pc    = 32'h0;
    out_ready   = 1'b0;
    model_pc    = 32'h0;
    #1;
    check("rst_iaddr", iaddr, 32'h0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_rd", {27'b0, rd}, 32'd0);
    check("rst_misalign", {31'b0, misalign}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Backpressure from the start: queue fills after two fetches, then the PC freezes at 8.
    repeat (5) step(1'b0, 32'h0, 1'b0);
    check("stall_iaddr", iaddr, 32'h8);
    repeat (6) step(1'b0, 32'h0, 1'b1);

    // Fill the queue, then redirect to 0x40 while full and decode is ready.
    repeat (3) step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h40, 1'b1);
    check("redir_iaddr", iaddr, 32'h40);
    check("redir_flush", {31'b0, out_valid}, 32'd0);
    step(1'b0, 32'h0, 1'b1);
    check("redir_head_pc", out_pc, 32'h40);
    check("redir_head_instr", out_instr, imem(32'h40));
    repeat (3) step(1'b0, 32'h0, 1'b1);

    // Back-to-back redirects: the second one wins; its head carries the decode-field test word.
    step(1'b1, 32'h200, 1'b1);
    step(1'b1, 32'h100, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    check("field_rs1", {27'b0, rs1}, 32'd10);
    check("field_rs2", {27'b0, rs2}, 32'd11);
    check("field_rd", {27'b0, rd}, 32'd10);
    repeat (2) step(1'b0, 32'h0, 1'b1);

    // PC wrap from the last word of the address space.
    step(1'b1, 32'hFFFF_FFFC, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    check("wrap_iaddr", iaddr, 32'h0);
    repeat (3) step(1'b0, 32'h0, 1'b1);

    // Asynchronous reset with a full queue, observed before any clock edge.
    repeat (3) step(1'b0, 32'h0, 1'b0);
    check("full_before_reset", {31'b0, out_valid}, 32'd1);
    reset = 1'b1;
    #1;
    check("async_out_valid", {31'b0, out_valid}, 32'd0);
    check("async_iaddr", iaddr, 32'h0);
    check("async_out_pc", out_pc, 32'h0);
    check("async_out_instr", out_instr, 32'h0);
    sb.delete();
    model_pc    = 32'h0;
    redir_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) step(1'b0, 32'h0, 1'b1);

    // Misaligned redirect in the default build: low bits dropped, fetching continues.
    step(1'b1, 32'h42, 1'b1);
    check("align_iaddr", iaddr, 32'h40);
    check("align_misalign", {31'b0, misalign}, 32'd0);
    repeat (4) step(1'b0, 32'h0, 1'b1);
    check("align_continue", iaddr, 32'h50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
